smi_flit_scale_stage_x2: RTL and testbench
==========================================

Name: smi_flit_scale_stage_x2

Overview:
Single SMI flit width scaling stage that doubles flit width. It packs pairs of consecutive input flits into one output flit, low half first. It is the expansion counterpart to the halving scaling stage and is cascaded to scale a narrow SMI link up to a wide one. It preserves frame boundaries and end-of-frame byte counts, and propagates back-pressure through a registered stop/ready handshake.

Parameters:
FlitWidth, 4, input flit width in bytes; power of two, 2..32; output flit width is 2*FlitWidth bytes.

Ports:
clk  input  1  clock; all logic on rising edge.
srst  input  1  reset; synchronous, active-high.
smiInReady  input  1  input flit valid.
smiInEofc  input  8  input end-of-frame control; 0 = not last; 1..FlitWidth = last flit with that many valid bytes (LSB-aligned).
smiInData  input  FlitWidth*8  input flit data; byte 0 in bits [7:0].
smiInStop  output  1  input back-pressure; the upstream holds the flit while this is high.
smiOutReady  output  1  output flit valid.
smiOutEofc  output  8  output end-of-frame control; 0 = not last; 1..2*FlitWidth = valid bytes in last flit.
smiOutData  output  FlitWidth*16  output flit data; earlier input flit in the low half.
smiOutStop  input  1  output back-pressure from downstream.

Behaviour:
- Handshake, both ports: a flit transfers on an edge where Ready=1 and Stop=0. While Ready=1 and Stop=1, Data and Eofc hold stable.
- Input register stage:
  - Captures smiInReady/Eofc/Data when not halted.
  - smiInStop = inReady_q & inHalt (registered valid AND combinational halt).
  - Eofc is masked to its low log2(2*FlitWidth) bits at capture. inLast_q = (captured eofc != 0).
- Pack state: phase bit, LOW/HIGH, plus a lowHalf register of FlitWidth*8 bits. Reset value: LOW.
- Output register stage: outReady_q, outData_q, outEofc_q. It updates only when ~(outReady_q & smiOutStop). Otherwise it holds.
- Combinational pack logic, applied when inReady_q=1:
  - LOW, inLast_q=0: lowHalf <= inData_q; phase -> HIGH; no output. Never halted by the output stage, so inHalt=0.
  - LOW, inLast_q=1: emit {zeros, inData_q} with eofc = inEofc_q; phase stays LOW. inHalt = outReady_q & smiOutStop.
  - HIGH, inLast_q=0: emit {inData_q, lowHalf} with eofc 0; phase -> LOW. inHalt = outReady_q & smiOutStop.
  - HIGH, inLast_q=1: emit {inData_q, lowHalf} with eofc = FlitWidth + inEofc_q (range FlitWidth+1..2*FlitWidth); phase -> LOW. Same halt rule.
  - When halted, the input flit is not consumed, and phase and lowHalf do not change.
- When inReady_q=0: no emit; outReady_d=0; state holds.
- Unused upper half of a last flit in the LOW phase is zero-filled, which makes it deterministic.
- Latency: an input flit accepted at edge k appears on smiOut after edge k+1 if it completes an output flit. Throughput is one output per two inputs, so at full streaming rate smiInStop is never asserted unless smiOutStop is.
- Reset:
  - smiOutReady=0, smiInStop=0, inReady_q=0, phase=LOW.
  - outData, outEofc and lowHalf are not reset; they are don't-care while smiOutReady=0.
  - Reset mid-frame discards any half-packed flit. The next frame starts in the LOW phase.
- Simultaneous events: a downstream stop release and a new emit on the same edge load the new flit that edge. Input capture and emit on the same edge are allowed, giving a fully pipelined datapath.
- Input eofc values above FlitWidth (after masking) are a protocol violation; the output is unspecified but must not deadlock.

Test Plan:
- Full-width frame, FlitWidth=4: inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 with eofc 0,0,0,4 -> outputs 0x2222222211111111 with eofc 0, then 0x4444444433333333 with eofc 8; no other smiOutReady pulses.
- Odd-length frame: 0xAAAAAAAA/0, 0xBBBBBBBB/0, 0x00CCCCCC/3 -> 0xBBBBBBBBAAAAAAAA with eofc 0, then 0x0000000000CCCCCC with eofc 3; the next frame's first flit lands in the low half.
- Single-flit frames back-to-back: 0x000000EE/1 followed immediately by 0x12345678/0, 0x9ABCDEF0/2 -> 0x00000000000000EE with eofc 1, then 0x9ABCDEF012345678 with eofc 6.
- Back-pressure: stream 16 flits, holding smiOutStop high for 5 cycles mid-stream -> smiInStop asserts within 2 cycles; smiOut Data/Eofc stay stable while stopped; 8 outputs in order with no loss or duplication.
- Reset mid-frame: accept 0x55555555/0, pulse srst, then send 0x66666666/0, 0x77777777/4 -> single output 0x7777777766666666 with eofc 8; no 0x5555 data is ever emitted.
- Streaming throughput: input valid every cycle with smiOutStop=0 for 20 flits -> smiInStop stays 0 throughout; smiOutReady is asserted on alternate cycles; 10 outputs.

Source files
------------

// File: rtl/smi_flit_scale_stage_x2.sv
// SMI flit width doubler: packs pairs of consecutive input flits into one
// output flit (earlier flit in the low half), preserving frame boundaries and
// end-of-frame byte counts, with a registered valid/stop handshake on both ports.
module smi_flit_scale_stage_x2 #(
    parameter int unsigned FlitWidth = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     smiInReady,
    input  logic [7:0]               smiInEofc,
    input  logic [FlitWidth*8-1:0]   smiInData,
    output logic                     smiInStop,
    output logic                     smiOutReady,
    output logic [7:0]               smiOutEofc,
    output logic [FlitWidth*16-1:0]  smiOutData,
    input  logic                     smiOutStop
);

    localparam int unsigned InW   = FlitWidth * 8;
    localparam int unsigned OutW  = 2 * InW;
    localparam int unsigned EofcW = $clog2(2 * FlitWidth);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    // Input register stage
    logic             in_ready_q;
    logic [EofcW-1:0] in_eofc_q;
    logic             in_last_q;
    logic [InW-1:0]   in_data_q;

    // Pack state
    phase_t           phase_q;
    phase_t           phase_d;
    logic [InW-1:0]   low_half_q;
    logic [InW-1:0]   low_half_d;

    // Output register stage
    logic             out_ready_q;
    logic [OutW-1:0]  out_data_q;
    logic [7:0]       out_eofc_q;

    // Combinational pack results
    logic             emit;
    logic             in_halt;
    logic             out_stall;
    logic [OutW-1:0]  out_data_d;
    logic [7:0]       out_eofc_d;

    // Upper eofc bits are ignored on capture
    logic             unused_eofc_hi;
    assign unused_eofc_hi = |smiInEofc[7:EofcW];

    assign out_stall   = out_ready_q & smiOutStop;
    assign smiInStop   = in_ready_q & in_halt;
    assign smiOutReady = out_ready_q;
    assign smiOutData  = out_data_q;
    assign smiOutEofc  = out_eofc_q;

    // Input valid register: reloads whenever the pack logic is not halted
    always_ff @(posedge clk) begin
        if (srst) begin
            in_ready_q <= 1'b0;
        end else if (!in_halt) begin
            in_ready_q <= smiInReady;
        end
    end

    // Input payload register: qualified by in_ready_q, so no reset needed
    always_ff @(posedge clk) begin
        if (!in_halt) begin
            in_eofc_q <= smiInEofc[EofcW-1:0];
            in_last_q <= |smiInEofc[EofcW-1:0];
            in_data_q <= smiInData;
        end
    end

    // Phase state register; a reset drops any half-packed flit
    always_ff @(posedge clk) begin
        if (srst) begin
            phase_q <= PH_LOW;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Low-half holding register: contents only meaningful in the HIGH phase
    always_ff @(posedge clk) begin
        low_half_q <= low_half_d;
    end

    // Pack next-state and emit logic
    always_comb begin
        phase_d    = phase_q;
        low_half_d = low_half_q;
        emit       = 1'b0;
        in_halt    = 1'b0;
        out_data_d = {in_data_q, low_half_q};
        out_eofc_d = 8'd0;

        if (in_ready_q) begin
            unique case (phase_q)
                PH_LOW: begin
                    if (!in_last_q) begin
                        // Park the first flit; needs no output slot, so never halts
                        low_half_d = in_data_q;
                        phase_d    = PH_HIGH;
                    end else begin
                        // Single-flit tail: zero-fill the upper half
                        emit       = 1'b1;
                        in_halt    = out_stall;
                        out_data_d = {{InW{1'b0}}, in_data_q};
                        out_eofc_d = 8'(in_eofc_q);
                    end
                end
                PH_HIGH: begin
                    emit       = 1'b1;
                    in_halt    = out_stall;
                    out_data_d = {in_data_q, low_half_q};
                    out_eofc_d = in_last_q ? (8'(FlitWidth) + 8'(in_eofc_q)) : 8'd0;
                    phase_d    = PH_LOW;
                end
                default: begin
                    phase_d = PH_LOW;
                end
            endcase

            if (in_halt) begin
                phase_d    = phase_q;
                low_half_d = low_half_q;
            end
        end
    end

    // Output valid register: holds while downstream stalls a pending flit
    always_ff @(posedge clk) begin
        if (srst) begin
            out_ready_q <= 1'b0;
        end else if (!out_stall) begin
            out_ready_q <= emit;
        end
    end

    // Output payload register: don't-care while smiOutReady is low
    always_ff @(posedge clk) begin
        if (!out_stall) begin
            out_data_q <= out_data_d;
            out_eofc_q <= out_eofc_d;
        end
    end

endmodule

// File: tb/tb_smi_flit_scale_stage_x2.sv
// Scoreboard bench for the SMI flit width doubler (FlitWidth = 4).
module tb_smi_flit_scale_stage_x2;

    localparam int unsigned FW = 4;
    localparam int unsigned DW = FW * 8;
    localparam int unsigned OW = 2 * DW;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [7:0]    eofc;
    } exp_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          smiInReady;
    logic [7:0]    smiInEofc;
    logic [DW-1:0] smiInData;
    logic          smiInStop;
    logic          smiOutReady;
    logic [7:0]    smiOutEofc;
    logic [OW-1:0] smiOutData;
    logic          smiOutStop;

    always #5 clk = ~clk;

    smi_flit_scale_stage_x2 #(.FlitWidth(FW)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInReady  (smiInReady),
        .smiInEofc   (smiInEofc),
        .smiInData   (smiInData),
        .smiInStop   (smiInStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    exp_t          sb[$];
    logic [OW-1:0] out_log[$];
    logic [7:0]    eofc_log[$];
    int            pulse_cyc[$];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            bp_start = 1000000;
    int            out_count = 0;
    int            in_stop_count = 0;
    int            first_in_stop = -1;
    logic          in_stop_s;
    logic          held = 1'b0;
    logic [OW-1:0] held_data;
    logic [7:0]    held_eofc;

    // Reference packer state
    logic          m_phase = 1'b0;
    logic [DW-1:0] m_low;

    // One clock: sample at negedge, drive just after posedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        in_stop_s = smiInStop;
        if (smiInStop === 1'b1) begin
            in_stop_count++;
            if (first_in_stop < 0) first_in_stop = cyc;
        end
        if (smiOutReady === 1'b1) begin
            if (held) begin
                checks++;
                if (smiOutData !== held_data || smiOutEofc !== held_eofc) begin
                    errors++;
                    $display("FAIL hold_stable: data %h eofc %0d, required data %h eofc %0d",
                             smiOutData, smiOutEofc, held_data, held_eofc);
                end
            end
            if (smiOutStop) begin
                held      = 1'b1;
                held_data = smiOutData;
                held_eofc = smiOutEofc;
            end else begin
                held = 1'b0;
                out_count++;
                pulse_cyc.push_back(cyc);
                out_log.push_back(smiOutData);
                eofc_log.push_back(smiOutEofc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data %h eofc %0d, required no output",
                             smiOutData, smiOutEofc);
                end else begin
                    e = sb.pop_front();
                    if (smiOutData !== e.data || smiOutEofc !== e.eofc) begin
                        errors++;
                        $display("FAIL out_flit: data %h eofc %0d, required data %h eofc %0d",
                                 smiOutData, smiOutEofc, e.data, e.eofc);
                    end
                end
            end
        end else begin
            held = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        smiOutStop = (cyc >= bp_start) && (cyc < bp_start + 5);
    endtask

    task automatic model_push(input logic [DW-1:0] data, input logic [7:0] eofc);
        exp_t x;
        logic [2:0] e;
        e = eofc[2:0];
        if (!m_phase) begin
            if (e == 3'd0) begin
                m_low   = data;
                m_phase = 1'b1;
            end else begin
                x.data = {{DW{1'b0}}, data};
                x.eofc = 8'(e);
                sb.push_back(x);
            end
        end else begin
            x.data  = {data, m_low};
            x.eofc  = (e == 3'd0) ? 8'd0 : 8'(FW + 32'(e));
            sb.push_back(x);
            m_phase = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] data, input logic [7:0] eofc);
        logic acc;
        acc        = 1'b0;
        smiInReady = 1'b1;
        smiInData  = data;
        smiInEofc  = eofc;
        model_push(data, eofc);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (in_stop_s === 1'b0) begin
                acc = 1'b1;
                break;
            end
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL in_accept: flit %h not accepted in 50 cycles, required acceptance", data);
        end
    endtask

    task automatic drain(input int n);
        smiInReady = 1'b0;
        repeat (n) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_outputs: %0d still expected, required 0", sb.size());
        end
    endtask

    task automatic clear_logs();
        out_count = 0;
        out_log.delete();
        eofc_log.delete();
        pulse_cyc.delete();
    endtask

    task automatic test_reset();
        srst       = 1'b1;
        smiInReady = 1'b0;
        smiInEofc  = 8'd0;
        smiInData  = '0;
        smiOutStop = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        checks++;
        if (smiOutReady !== 1'b0 || smiInStop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outReady %b inStop %b, required 0 0", smiOutReady, smiInStop);
        end
        srst = 1'b0;
        tick();
        tick();
        checks++;
        if (smiOutReady !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: outReady %b, required 0", smiOutReady);
        end
    endtask

    task automatic test_full_frame();
        clear_logs();
        send(32'h11111111, 8'd0);
        send(32'h22222222, 8'd0);
        send(32'h33333333, 8'd0);
        send(32'h44444444, 8'd4);
        drain(5);
        checks++;
        if (out_count != 2) begin
            errors++;
            $display("FAIL full_count: %0d outputs, required 2", out_count);
        end else begin
            checks++;
            if (out_log[0] !== 64'h2222222211111111 || eofc_log[0] !== 8'd0 ||
                out_log[1] !== 64'h4444444433333333 || eofc_log[1] !== 8'd8) begin
                errors++;
                $display("FAIL full_values: %h/%0d %h/%0d, required 2222222211111111/0 4444444433333333/8",
                         out_log[0], eofc_log[0], out_log[1], eofc_log[1]);
            end
        end
    endtask

    task automatic test_odd_frame();
        clear_logs();
        send(32'hAAAAAAAA, 8'd0);
        send(32'hBBBBBBBB, 8'd0);
        send(32'h00CCCCCC, 8'd3);
        send(32'h01010101, 8'd0);
        send(32'h00000002, 8'd1);
        drain(5);
        checks++;
        if (out_count != 3) begin
            errors++;
            $display("FAIL odd_count: %0d outputs, required 3", out_count);
        end else begin
            checks++;
            if (out_log[0] !== 64'hBBBBBBBBAAAAAAAA || eofc_log[0] !== 8'd0 ||
                out_log[1] !== 64'h0000000000CCCCCC || eofc_log[1] !== 8'd3 ||
                out_log[2] !== 64'h0000000201010101 || eofc_log[2] !== 8'd5) begin
                errors++;
                $display("FAIL odd_values: %h/%0d %h/%0d %h/%0d, required BBBBBBBBAAAAAAAA/0 0000000000CCCCCC/3 0000000201010101/5",
                         out_log[0], eofc_log[0], out_log[1], eofc_log[1], out_log[2], eofc_log[2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send(32'h000000EE, 8'd1);
        send(32'h12345678, 8'd0);
        send(32'h9ABCDEF0, 8'd2);
        drain(5);
        checks++;
        if (out_count != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d outputs, required 2", out_count);
        end else begin
            checks++;
            if (out_log[0] !== 64'h00000000000000EE || eofc_log[0] !== 8'd1 ||
                out_log[1] !== 64'h9ABCDEF012345678 || eofc_log[1] !== 8'd6) begin
                errors++;
                $display("FAIL b2b_values: %h/%0d %h/%0d, required 00000000000000EE/1 9ABCDEF012345678/6",
                         out_log[0], eofc_log[0], out_log[1], eofc_log[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int bp;
        clear_logs();
        first_in_stop = -1;
        bp            = cyc + 6;
        bp_start      = bp;
        for (int i = 0; i < 16; i++) begin
            send(32'hC0DE0000 + 32'(i), (i == 15) ? 8'd4 : 8'd0);
        end
        drain(12);
        bp_start = 1000000;
        checks++;
        if (out_count != 8) begin
            errors++;
            $display("FAIL bp_count: %0d outputs, required 8", out_count);
        end
        checks++;
        if (first_in_stop < bp || first_in_stop > bp + 2) begin
            errors++;
            $display("FAIL bp_in_stop: first inStop at cycle %0d, required %0d..%0d",
                     first_in_stop, bp, bp + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send(32'h55555555, 8'd0);
        smiInReady = 1'b0;
        tick();
        srst = 1'b1;
        tick();
        checks++;
        if (smiOutReady !== 1'b0 || smiInStop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: outReady %b inStop %b, required 0 0", smiOutReady, smiInStop);
        end
        tick();
        srst    = 1'b0;
        m_phase = 1'b0;
        sb.delete();
        send(32'h66666666, 8'd0);
        send(32'h77777777, 8'd4);
        drain(5);
        checks++;
        if (out_count != 1) begin
            errors++;
            $display("FAIL mid_reset_count: %0d outputs, required 1", out_count);
        end else begin
            checks++;
            if (out_log[0] !== 64'h7777777766666666 || eofc_log[0] !== 8'd8) begin
                errors++;
                $display("FAIL mid_reset_value: %h/%0d, required 7777777766666666/8",
                         out_log[0], eofc_log[0]);
            end
        end
    endtask

    task automatic test_streaming();
        int bad;
        clear_logs();
        in_stop_count = 0;
        bad           = 0;
        for (int i = 0; i < 20; i++) begin
            send(32'hA5000000 + 32'(i * 3), (i == 19) ? 8'd4 : 8'd0);
        end
        drain(5);
        checks++;
        if (in_stop_count != 0) begin
            errors++;
            $display("FAIL stream_in_stop: %0d stop cycles, required 0", in_stop_count);
        end
        checks++;
        if (out_count != 10) begin
            errors++;
            $display("FAIL stream_count: %0d outputs, required 10", out_count);
        end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            if (pulse_cyc[i] - pulse_cyc[i-1] != 2) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_spacing: %0d gaps not equal to 2 cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_odd_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
